ctx_ram: RTL and testbench
==========================

CTX_RAM -- requirements
Module: ctx_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: width of the CPU address port.
REQ-003 SHALL have parameter DEPTH, default 82: number of words in the storage array.
REQ-004 SHALL have parameter NREG, default 31: number of register words in one save/load context.
REQ-005 SHALL have parameter CTX_BASE, default 0: first array index of the context region.
REQ-006 SHALL have parameter USER_BASE, default 31: array index that CPU address 0 maps to.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port data, input, DATA_W bits: CPU write data.
REQ-010 SHALL have port addr, input, ADDR_W bits: CPU word address.
REQ-011 SHALL have port mW, input, 1 bit: CPU write enable.
REQ-012 SHALL have port DataOut, output, DATA_W bits: CPU read data.
REQ-013 SHALL have port Dump, input, NREG*DATA_W bits: register-file image; word i is bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port LDump, output, NREG*DATA_W bits: restored register image, registered, same word packing as Dump.
REQ-015 SHALL have port Save, input, 1 bit: request to start a context save.
REQ-016 SHALL have port Load, input, 1 bit: request to start a context load.
REQ-017 SHALL have port busy, output, 1 bit: high while a save or load sequence is running.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-019 SHALL have port addr_err, output, 1 bit: combinational flag, high when addr+USER_BASE >= DEPTH.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, SAVE, LOAD; a word index idx counts 0..NREG-1.
REQ-021 SHALL drive DataOut combinationally as the array word at addr+USER_BASE, and SHALL drive DataOut to 0 when addr_err is high.
REQ-022 SHALL write data to the array word at addr+USER_BASE on a rising edge where mW=1, busy=0 and addr_err=0; all other CPU writes SHALL be dropped.
REQ-023 SHALL, in IDLE with Save=1 at edge E0, capture Dump into an internal snapshot register, set idx=0 and enter SAVE.
REQ-024 SHALL, in SAVE at edges E1..E_NREG, write snapshot word idx to array word CTX_BASE+idx and increment idx; Dump changes after E0 SHALL NOT affect the saved data.
REQ-025 SHALL, in IDLE with Load=1 and Save=0 at edge E0, set idx=0 and enter LOAD.
REQ-026 SHALL, in LOAD at edges E1..E_NREG, copy array word CTX_BASE+idx into LDump word idx; LDump SHALL update progressively, word by word, during the load.
REQ-027 SHALL return to IDLE at edge E_NREG and SHALL drive done high for exactly the cycle following E_NREG.
REQ-028 SHALL hold busy high for exactly NREG cycles, from after E0 through edge E_NREG.
REQ-029 SHALL give Save priority when Save and Load are both high in IDLE; the Load SHALL be discarded.
REQ-030 SHALL ignore Save and Load while busy; they SHALL NOT be queued.
REQ-031 SHALL keep DataOut reads valid while busy.
REQ-032 SHALL hold LDump stable between loads.
REQ-033 SHALL keep NREG, CTX_BASE, USER_BASE and DEPTH consistent: CTX_BASE+NREG <= DEPTH and the context region disjoint from the user region; violation SHALL be a compile-time error.
REQ-034 SHALL compute addr+USER_BASE at a width of at least ADDR_W+1 bits so the sum does not wrap.

Reset
REQ-035 SHALL, on rst=1, asynchronously force: FSM to IDLE, idx=0, busy=0, done=0, LDump=0 and snapshot=0.
REQ-036 SHALL NOT clear array contents on reset; words already written by an interrupted save SHALL remain and the rest SHALL keep their prior values.
REQ-037 SHALL, on a reset during LOAD, leave LDump at 0 after reset with no partial data.

Verification
REQ-038 SHALL pass this scenario: write 0xDEADBEEF at addr 5, then read addr 5 -> DataOut=0xDEADBEEF and array word 36 holds the value.
REQ-039 SHALL pass this scenario: Dump word i = 0x100+i, pulse Save, change Dump to 0 at the next cycle, wait for done -> busy high for 31 cycles, done for 1 cycle, array words 0..30 = 0x100..0x11E.
REQ-040 SHALL pass this scenario: after REQ-039, pulse Load -> done after 31 cycles and LDump word i = 0x100+i.
REQ-041 SHALL pass this scenario: Save and Load high together in IDLE -> save runs and LDump is unchanged; a Load pulse mid-save -> ignored, with no second done.
REQ-042 SHALL pass this scenario: mW=1 at addr 3 while busy -> word 34 unchanged; addr=51 -> addr_err=1, DataOut=0, write dropped.
REQ-043 SHALL pass this scenario: rst asserted at save word 10 -> busy=0 immediately, words 0..9 hold new values, words 10..30 hold old values.

Source files
------------

// File: rtl/ctx_ram.sv
// Word-addressed RAM with a CPU port and a sequencer that saves/restores a
// register-file image to a reserved context region, one word per cycle.
module ctx_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 82,
    parameter int NREG      = 31,
    parameter int CTX_BASE  = 0,
    parameter int USER_BASE = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     mW,
    output logic [DATA_W-1:0]        DataOut,
    input  logic [NREG*DATA_W-1:0]   Dump,
    output logic [NREG*DATA_W-1:0]   LDump,
    input  logic                     Save,
    input  logic                     Load,
    output logic                     busy,
    output logic                     done,
    output logic                     addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (NREG > 1) ? $clog2(NREG) : 1;
    // One bit wider than both the CPU address and the array index so the
    // user offset can never wrap back into range.
    localparam int SUM_W = ((ADDR_W > IDX_W) ? ADDR_W : IDX_W) + 1;

    if (CTX_BASE + NREG > DEPTH) begin : g_ctx_overflow
        $error("ctx_ram: context region runs past the end of the array");
    end
    if ((CTX_BASE + NREG > USER_BASE) || (USER_BASE > DEPTH)) begin : g_ctx_overlap
        $error("ctx_ram: context region overlaps the user region");
    end

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        LOAD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        idx;
    logic [CNT_W-1:0]        idx_next;
    logic                    done_next;
    logic                    snap_capture;
    logic                    save_we;
    logic                    load_we;
    logic                    cpu_we;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [NREG*DATA_W-1:0]  snapshot;
    logic [NREG*DATA_W-1:0]  ldump_r;

    logic [SUM_W-1:0]        user_sum;
    logic [IDX_W-1:0]        user_idx;
    logic [IDX_W-1:0]        ctx_idx;

    assign user_sum = SUM_W'(addr) + SUM_W'(USER_BASE);
    assign addr_err = (user_sum >= SUM_W'(DEPTH));
    assign user_idx = user_sum[IDX_W-1:0];
    assign ctx_idx  = IDX_W'(CTX_BASE) + IDX_W'(idx);

    assign busy    = (state != IDLE);
    assign cpu_we  = mW && !busy && !addr_err;
    assign DataOut = addr_err ? '0 : mem[user_idx];
    assign LDump   = ldump_r;

    // Save wins over a simultaneous Load; requests seen while busy are dropped.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        done_next    = 1'b0;
        snap_capture = 1'b0;
        save_we      = 1'b0;
        load_we      = 1'b0;
        case (state)
            IDLE: begin
                if (Save) begin
                    state_next   = SAVE;
                    idx_next     = '0;
                    snap_capture = 1'b1;
                end else if (Load) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            SAVE: begin
                save_we = 1'b1;
                if (idx == CNT_W'(NREG - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx + CNT_W'(1);
                end
            end
            LOAD: begin
                load_we = 1'b1;
                if (idx == CNT_W'(NREG - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            done     <= 1'b0;
            snapshot <= '0;
            ldump_r  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            done  <= done_next;
            if (snap_capture) begin
                snapshot <= Dump;
            end
            if (load_we) begin
                ldump_r[idx*DATA_W +: DATA_W] <= mem[ctx_idx];
            end
        end
    end

    // The array is deliberately outside reset so an interrupted save leaves
    // its already-written words and the untouched remainder intact.
    always_ff @(posedge clk) begin
        if (save_we) begin
            mem[ctx_idx] <= snapshot[idx*DATA_W +: DATA_W];
        end else if (cpu_we) begin
            mem[user_idx] <= data;
        end
    end

endmodule

// File: tb/tb_ctx_ram.sv
// Directed self-checking bench for ctx_ram: CPU port, save/load sequencing,
// arbitration, dropped writes and reset in the middle of a sequence.
module tb_ctx_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int NREG   = 31;

    logic                    clk;
    logic                    rst;
    logic [DATA_W-1:0]       data;
    logic [ADDR_W-1:0]       addr;
    logic                    mW;
    logic [DATA_W-1:0]       DataOut;
    logic [NREG*DATA_W-1:0]  Dump;
    logic [NREG*DATA_W-1:0]  LDump;
    logic                    Save;
    logic                    Load;
    logic                    busy;
    logic                    done;
    logic                    addr_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [NREG*DATA_W-1:0]  exp_vec;

    ctx_ram dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .addr     (addr),
        .mW       (mW),
        .DataOut  (DataOut),
        .Dump     (Dump),
        .LDump    (LDump),
        .Save     (Save),
        .Load     (Load),
        .busy     (busy),
        .done     (done),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_dump(input logic [DATA_W-1:0] base);
        for (int i = 0; i < NREG; i++) Dump[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; data = '0; addr = '0; mW = 1'b0; Save = 1'b0; Load = 1'b0; Dump = '0;
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
        else pass_cnt++;
        total_cnt++;
        if (LDump !== '0) $display("[TB] FAIL reset_ldump: got %h expected 0", LDump);
        else pass_cnt++;
        total_cnt++;
        if (addr_err !== 1'b0) $display("[TB] FAIL reset_addr_err: got %b expected 0", addr_err);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_rw();
        addr = 10'd5; data = 32'hDEADBEEF; mW = 1'b1;
        tick();
        mW = 1'b0; data = '0;
        total_cnt++;
        if (DataOut !== 32'hDEADBEEF) $display("[TB] FAIL rw_addr5: got %h expected deadbeef", DataOut);
        else pass_cnt++;
        total_cnt++;
        if (dut.mem[36] !== 32'hDEADBEEF) $display("[TB] FAIL rw_word36: got %h expected deadbeef", dut.mem[36]);
        else pass_cnt++;
        addr = 10'd50; data = 32'h1234_5678; mW = 1'b1;
        tick();
        mW = 1'b0;
        total_cnt++;
        if (addr_err !== 1'b0 || DataOut !== 32'h1234_5678)
            $display("[TB] FAIL rw_last_word: got err=%b data=%h expected err=0 data=12345678", addr_err, DataOut);
        else pass_cnt++;
        total_cnt++;
        if (dut.mem[81] !== 32'h1234_5678) $display("[TB] FAIL rw_word81: got %h expected 12345678", dut.mem[81]);
        else pass_cnt++;
        addr = 10'd0; data = 32'h0000_CAFE; mW = 1'b1;
        tick();
        mW = 1'b0;
        total_cnt++;
        if (dut.mem[31] !== 32'h0000_CAFE) $display("[TB] FAIL rw_word31: got %h expected 0000cafe", dut.mem[31]);
        else pass_cnt++;
    endtask

    task automatic test_save();
        int cnt;
        fill_dump(32'h100);
        addr = 10'd5;
        Save = 1'b1;
        tick();
        Save = 1'b0;
        Dump = '0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                total_cnt++;
                if (DataOut !== 32'hDEADBEEF) $display("[TB] FAIL save_read_busy: got %h expected deadbeef", DataOut);
                else pass_cnt++;
            end
            tick();
        end
        total_cnt++;
        if (cnt != NREG) $display("[TB] FAIL save_busy_len: got %0d expected %0d", cnt, NREG);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1) $display("[TB] FAIL save_done: got %b expected 1", done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL save_done_width: got %b expected 0", done);
        else pass_cnt++;
        for (int i = 0; i < NREG; i++) begin
            total_cnt++;
            if (dut.mem[i] !== 32'h100 + DATA_W'(i))
                $display("[TB] FAIL save_word%0d: got %h expected %h", i, dut.mem[i], 32'h100 + DATA_W'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        int cnt;
        for (int i = 0; i < NREG; i++) exp_vec[i*DATA_W +: DATA_W] = 32'h100 + DATA_W'(i);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                total_cnt++;
                if (LDump[31:0] !== 32'h100 || LDump[63:32] !== 32'h0)
                    $display("[TB] FAIL load_progressive: got w0=%h w1=%h expected w0=00000100 w1=00000000", LDump[31:0], LDump[63:32]);
                else pass_cnt++;
            end
            tick();
        end
        total_cnt++;
        if (cnt != NREG) $display("[TB] FAIL load_busy_len: got %0d expected %0d", cnt, NREG);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1) $display("[TB] FAIL load_done: got %b expected 1", done);
        else pass_cnt++;
        total_cnt++;
        if (LDump !== exp_vec) $display("[TB] FAIL load_image: got %h expected %h", LDump, exp_vec);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_priority();
        int dones;
        fill_dump(32'h200);
        Save = 1'b1; Load = 1'b1;
        tick();
        Save = 1'b0; Load = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("[TB] FAIL prio_busy: got %b expected 1", busy);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        Load = 1'b1;
        tick();
        Load = 1'b0;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        total_cnt++;
        if (dones != 1) $display("[TB] FAIL prio_done_count: got %0d expected 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (LDump !== exp_vec) $display("[TB] FAIL prio_ldump_kept: got %h expected %h", LDump, exp_vec);
        else pass_cnt++;
        total_cnt++;
        if (dut.mem[0] !== 32'h200 || dut.mem[30] !== 32'h21E)
            $display("[TB] FAIL prio_saved: got w0=%h w30=%h expected 00000200 0000021e", dut.mem[0], dut.mem[30]);
        else pass_cnt++;
    endtask

    task automatic test_dropped_writes();
        int cnt;
        addr = 10'd3; data = 32'hA5A5_0003; mW = 1'b1;
        tick();
        mW = 1'b0;
        fill_dump(32'h300);
        Save = 1'b1;
        tick();
        Save = 1'b0;
        tick();
        addr = 10'd3; data = 32'h0000_0BAD; mW = 1'b1;
        tick();
        mW = 1'b0;
        total_cnt++;
        if (dut.mem[34] !== 32'hA5A5_0003) $display("[TB] FAIL busy_write_dropped: got %h expected a5a50003", dut.mem[34]);
        else pass_cnt++;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        total_cnt++;
        if (busy !== 1'b0) $display("[TB] FAIL busy_write_timeout: got busy=%b expected 0", busy);
        else pass_cnt++;
        tick();
        addr = 10'd51; data = 32'hFFFF_FFFF; mW = 1'b1;
        #1;
        total_cnt++;
        if (addr_err !== 1'b1 || DataOut !== 32'h0)
            $display("[TB] FAIL err_addr51: got err=%b data=%h expected err=1 data=0", addr_err, DataOut);
        else pass_cnt++;
        tick();
        mW = 1'b0;
        total_cnt++;
        if (dut.mem[81] !== 32'h1234_5678 || dut.mem[31] !== 32'h0000_CAFE)
            $display("[TB] FAIL err_write_dropped: got w81=%h w31=%h expected 12345678 0000cafe", dut.mem[81], dut.mem[31]);
        else pass_cnt++;
        addr = 10'd1023;
        #1;
        total_cnt++;
        if (addr_err !== 1'b1 || DataOut !== 32'h0)
            $display("[TB] FAIL err_addr1023: got err=%b data=%h expected err=1 data=0", addr_err, DataOut);
        else pass_cnt++;
        addr = 10'd5;
        tick();
    endtask

    task automatic test_reset_mid_save();
        int bad;
        fill_dump(32'h400);
        Save = 1'b1;
        tick();
        Save = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL rst_save_flags: got busy=%b done=%b expected 0 0", busy, done);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < NREG; i++) begin
            if (i < 10 && dut.mem[i] !== 32'h400 + DATA_W'(i)) bad++;
            if (i >= 10 && dut.mem[i] !== 32'h300 + DATA_W'(i)) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("[TB] FAIL rst_save_words: got %0d wrong words (w9=%h w10=%h) expected 0 (00000409 0000030a)", bad, dut.mem[9], dut.mem[10]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (LDump[4*DATA_W +: DATA_W] !== 32'h404 || LDump[5*DATA_W +: DATA_W] !== 32'h0)
            $display("[TB] FAIL rst_load_partial: got w4=%h w5=%h expected 00000404 00000000",
                     LDump[4*DATA_W +: DATA_W], LDump[5*DATA_W +: DATA_W]);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (LDump !== '0 || busy !== 1'b0)
            $display("[TB] FAIL rst_load_clear: got busy=%b ldump=%h expected busy=0 ldump=0", busy, LDump);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (LDump !== '0 || done !== 1'b0)
            $display("[TB] FAIL rst_load_stable: got done=%b ldump=%h expected done=0 ldump=0", done, LDump);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_save();
        test_load();
        test_priority();
        test_dropped_writes();
        test_reset_mid_save();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
